// File: rtl/mem_arbiter_pkg.sv
// Shared encodings and defaults for the icache/dcache memory-port arbiter.
package mem_arbiter_pkg;

    // Arbiter FSM states: idle, or port held by one cache.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_I = 2'd1,
        OWN_D = 2'd2
    } state_t;

    // Port owner encoding, also driven on o_owner.
    typedef enum logic [1:0] {
        OWNER_NONE = 2'b00,
        OWNER_IC   = 2'b01,
        OWNER_DC   = 2'b10
    } owner_t;

    // One cache line of four words may be in flight.
    localparam int MAX_OUTSTANDING_DEF = 4;
    localparam int CNT_W_DEF           = 3;

endpackage

// File: rtl/mem_arb_outstanding_ctr.sv
// Up/down counter of reads accepted by memory but not yet answered.
// Saturates at MAX_OUTSTANDING and never wraps below zero; a decrement
// at zero is flagged as an underflow and otherwise ignored.
module mem_arb_outstanding_ctr #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_W           = 3
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_inc,
    input  logic             i_dec,
    output logic [CNT_W-1:0] o_count_next,
    output logic             o_full,
    output logic             o_zero,
    output logic             o_underflow
);

    logic [CNT_W-1:0] r_count;
    logic             w_inc_ok;
    logic             w_dec_ok;

    assign o_zero      = (r_count == '0);
    assign o_full      = (r_count >= CNT_W'(MAX_OUTSTANDING));
    assign o_underflow = i_dec & o_zero;
    assign w_dec_ok    = i_dec & ~o_zero;
    assign w_inc_ok    = i_inc & (~o_full | w_dec_ok);

    // Next count: simultaneous inc and dec cancel out.
    always_comb begin
        o_count_next = r_count;
        if (w_inc_ok && !w_dec_ok) begin
            o_count_next = r_count + CNT_W'(1);
        end else if (!w_inc_ok && w_dec_ok) begin
            o_count_next = r_count - CNT_W'(1);
        end
    end

    // Count register, cleared immediately by reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else begin
            r_count <= o_count_next;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one backing-memory port between icache and dcache. A winner is
// picked combinationally in IDLE (round-robin on ties) and keeps the port
// until all its reads have returned and it stops requesting.
// Handshake: a request (ren|wen) is accepted on a cycle where the client's
// ready is high; the client holds addr/ren/wen/wdata stable until then.
// Read data returns in order, flagged by o_x_valid, with no back-pressure.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEF,
    parameter int CNT_W           = CNT_W_DEF
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_ic_ren,
    input  logic        i_ic_wen,
    input  logic [31:0] i_ic_addr,
    input  logic [31:0] i_ic_wdata,
    output logic        o_ic_ready,
    output logic [31:0] o_ic_rdata,
    output logic        o_ic_valid,
    input  logic        i_dc_ren,
    input  logic        i_dc_wen,
    input  logic [31:0] i_dc_addr,
    input  logic [31:0] i_dc_wdata,
    output logic        o_dc_ready,
    output logic [31:0] o_dc_rdata,
    output logic        o_dc_valid,
    input  logic        i_mem_ready,
    output logic [31:0] o_mem_addr,
    output logic        o_mem_ren,
    output logic        o_mem_wen,
    output logic [31:0] o_mem_wdata,
    input  logic [31:0] i_mem_rdata,
    input  logic        i_mem_valid,
    output logic [1:0]  o_owner,
    output logic        o_protocol_err
);

    state_t           r_state, w_state_next;
    owner_t           r_last_grant, w_last_grant_next;
    owner_t           w_sel;
    logic             r_err, w_err_next;
    logic             w_ic_req, w_dc_req;
    logic             w_sel_ren, w_sel_wen;
    logic [31:0]      w_sel_addr, w_sel_wdata;
    logic             w_rd, w_wr, w_ready, w_accept, w_inc;
    logic             w_full, w_zero, w_underflow;
    logic [CNT_W-1:0] w_count_next;

    assign w_ic_req = i_ic_ren | i_ic_wen;
    assign w_dc_req = i_dc_ren | i_dc_wen;

    // Selected client: round-robin winner in IDLE, otherwise the owner.
    always_comb begin
        w_sel = OWNER_NONE;
        case (r_state)
            IDLE: begin
                if (w_ic_req && w_dc_req) begin
                    w_sel = (r_last_grant == OWNER_IC) ? OWNER_DC : OWNER_IC;
                end else if (w_ic_req) begin
                    w_sel = OWNER_IC;
                end else if (w_dc_req) begin
                    w_sel = OWNER_DC;
                end
            end
            OWN_I:   w_sel = OWNER_IC;
            OWN_D:   w_sel = OWNER_DC;
            default: w_sel = OWNER_NONE;
        endcase
    end

    // Request mux; an idle port presents all zeros.
    always_comb begin
        w_sel_ren   = 1'b0;
        w_sel_wen   = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        case (w_sel)
            OWNER_IC: begin
                w_sel_ren   = i_ic_ren;
                w_sel_wen   = i_ic_wen;
                w_sel_addr  = i_ic_addr;
                w_sel_wdata = i_ic_wdata;
            end
            OWNER_DC: begin
                w_sel_ren   = i_dc_ren;
                w_sel_wen   = i_dc_wen;
                w_sel_addr  = i_dc_addr;
                w_sel_wdata = i_dc_wdata;
            end
            default: ;
        endcase
    end

    // ren together with wen is illegal: the write wins, the read is dropped.
    assign w_wr     = w_sel_wen;
    assign w_rd     = w_sel_ren & ~w_sel_wen;
    // Reads stall while the outstanding window is full; writes never do.
    assign w_ready  = i_mem_ready & (w_sel != OWNER_NONE) & (w_wr | ~w_full);
    assign w_accept = w_ready & (w_rd | w_wr);
    assign w_inc    = w_ready & w_rd;

    assign o_mem_addr  = w_sel_addr;
    assign o_mem_wdata = w_sel_wdata;
    assign o_mem_wen   = w_wr;
    assign o_mem_ren   = w_rd & ~w_full;

    assign o_ic_ready = (w_sel == OWNER_IC) & w_ready;
    assign o_dc_ready = (w_sel == OWNER_DC) & w_ready;

    // Responses are broadcast; valid is steered to the owner only, and a
    // response with nothing outstanding is dropped.
    assign o_ic_rdata = i_mem_rdata;
    assign o_dc_rdata = i_mem_rdata;
    assign o_ic_valid = i_mem_valid & ~w_zero & (r_state == OWN_I);
    assign o_dc_valid = i_mem_valid & ~w_zero & (r_state == OWN_D);

    assign o_owner        = (r_state == OWN_I) ? OWNER_IC :
                            (r_state == OWN_D) ? OWNER_DC : OWNER_NONE;
    assign o_protocol_err = r_err;

    mem_arb_outstanding_ctr #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING),
        .CNT_W           (CNT_W)
    ) u_ctr (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_inc        (w_inc),
        .i_dec        (i_mem_valid),
        .o_count_next (w_count_next),
        .o_full       (w_full),
        .o_zero       (w_zero),
        .o_underflow  (w_underflow)
    );

    // Next state: grant on acceptance, release once drained and quiet.
    always_comb begin
        w_state_next      = r_state;
        w_last_grant_next = r_last_grant;
        w_err_next        = r_err | w_underflow | (w_sel_ren & w_sel_wen);
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_last_grant_next = w_sel;
                    w_state_next      = (w_sel == OWNER_IC) ? OWN_I : OWN_D;
                end
            end
            OWN_I, OWN_D: begin
                if ((w_count_next == '0) && !w_sel_ren && !w_sel_wen) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // State, last grant and sticky error registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= IDLE;
            r_last_grant <= OWNER_IC;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_last_grant <= w_last_grant_next;
            r_err        <= w_err_next;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: refill, tie-breaking, full window,
// memory stall, protocol errors and reset recovery.
module tb_mem_arbiter;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_ic_ren, i_ic_wen, i_dc_ren, i_dc_wen;
    logic [31:0] i_ic_addr, i_ic_wdata, i_dc_addr, i_dc_wdata;
    logic        o_ic_ready, o_ic_valid, o_dc_ready, o_dc_valid;
    logic [31:0] o_ic_rdata, o_dc_rdata;
    logic        i_mem_ready, i_mem_valid;
    logic [31:0] i_mem_rdata, o_mem_addr, o_mem_wdata;
    logic        o_mem_ren, o_mem_wen;
    logic [1:0]  o_owner;
    logic        o_protocol_err;

    int n_tests = 0;
    int n_fail  = 0;

    mem_arbiter dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_ic_ren       (i_ic_ren),
        .i_ic_wen       (i_ic_wen),
        .i_ic_addr      (i_ic_addr),
        .i_ic_wdata     (i_ic_wdata),
        .o_ic_ready     (o_ic_ready),
        .o_ic_rdata     (o_ic_rdata),
        .o_ic_valid     (o_ic_valid),
        .i_dc_ren       (i_dc_ren),
        .i_dc_wen       (i_dc_wen),
        .i_dc_addr      (i_dc_addr),
        .i_dc_wdata     (i_dc_wdata),
        .o_dc_ready     (o_dc_ready),
        .o_dc_rdata     (o_dc_rdata),
        .o_dc_valid     (o_dc_valid),
        .i_mem_ready    (i_mem_ready),
        .o_mem_addr     (o_mem_addr),
        .o_mem_ren      (o_mem_ren),
        .o_mem_wen      (o_mem_wen),
        .o_mem_wdata    (o_mem_wdata),
        .i_mem_rdata    (i_mem_rdata),
        .i_mem_valid    (i_mem_valid),
        .o_owner        (o_owner),
        .o_protocol_err (o_protocol_err)
    );

    // Clock.
    always #5 i_clk = ~i_clk;

    // All comparisons go through here.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Apply one cycle of inputs (just after a rising edge) and let them settle.
    task automatic drv(input logic ic_ren, input logic ic_wen, input logic [31:0] ic_addr,
                       input logic [31:0] ic_wdata, input logic dc_ren, input logic dc_wen,
                       input logic [31:0] dc_addr, input logic [31:0] dc_wdata,
                       input logic mready, input logic mvalid, input logic [31:0] mrdata);
        i_ic_ren    = ic_ren;
        i_ic_wen    = ic_wen;
        i_ic_addr   = ic_addr;
        i_ic_wdata  = ic_wdata;
        i_dc_ren    = dc_ren;
        i_dc_wen    = dc_wen;
        i_dc_addr   = dc_addr;
        i_dc_wdata  = dc_wdata;
        i_mem_ready = mready;
        i_mem_valid = mvalid;
        i_mem_rdata = mrdata;
        #2;
    endtask

    task automatic quiet();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    endtask

    task automatic next_cyc();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0;
        quiet();
        next_cyc();
        i_rst_n = 1'b1;
    endtask

    initial begin
        // ---- reset values
        i_rst_n = 1'b0;
        quiet();
        next_cyc();
        check("rst_owner", o_owner, 2'b00);
        check("rst_err", o_protocol_err, 0);
        check("rst_mem_addr", o_mem_addr, 0);
        check("rst_mem_ren", o_mem_ren, 0);
        check("rst_mem_wen", o_mem_wen, 0);
        check("rst_ic_ready", o_ic_ready, 0);
        check("rst_dc_ready", o_dc_ready, 0);
        check("rst_ic_valid", o_ic_valid, 0);
        i_rst_n = 1'b1;
        next_cyc();

        // ---- icache 4-word refill, data back 2 cycles after each accept
        for (int k = 0; k < 7; k++) begin
            drv(k < 4, 0, 32'h100 + 32'(4 * k), 0, 0, 0, 0, 0, 1,
                (k >= 2) && (k < 6), 32'hA000_0000 + 32'(k));
            if (k < 4) begin
                check($sformatf("t1_addr%0d", k), o_mem_addr, 32'h100 + 32'(4 * k));
                check($sformatf("t1_ready%0d", k), o_ic_ready, 1);
            end
            check($sformatf("t1_owner%0d", k), o_owner, (k == 0 || k == 6) ? 2'b00 : 2'b01);
            check($sformatf("t1_icv%0d", k), o_ic_valid, (k >= 2) && (k < 6));
            check($sformatf("t1_dcv%0d", k), o_dc_valid, 0);
            if (k >= 2 && k < 6)
                check($sformatf("t1_rdata%0d", k), o_ic_rdata, 32'hA000_0000 + 32'(k));
            next_cyc();
        end

        // ---- tie right after reset: dcache wins
        do_reset();
        drv(1, 0, 32'h40, 0, 0, 1, 32'h80, 32'hDEADBEEF, 1, 0, 0);
        check("t2_wen", o_mem_wen, 1);
        check("t2_ren", o_mem_ren, 0);
        check("t2_addr", o_mem_addr, 32'h80);
        check("t2_wdata", o_mem_wdata, 32'hDEADBEEF);
        check("t2_dc_ready", o_dc_ready, 1);
        check("t2_ic_ready", o_ic_ready, 0);
        next_cyc();
        drv(1, 0, 32'h40, 0, 0, 0, 0, 0, 1, 0, 0);
        check("t2_owner_d", o_owner, 2'b10);
        check("t2_ic_blocked", o_ic_ready, 0);
        check("t2_ren_blocked", o_mem_ren, 0);
        next_cyc();
        drv(1, 0, 32'h40, 0, 0, 0, 0, 0, 1, 0, 0);
        check("t2_ic_grant", o_ic_ready, 1);
        check("t2_ic_addr", o_mem_addr, 32'h40);
        next_cyc();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h1234);
        check("t2_ic_valid", o_ic_valid, 1);
        check("t2_owner_i", o_owner, 2'b01);
        next_cyc();
        quiet();
        check("t2_idle", o_owner, 2'b00);

        // ---- back-to-back ties (last grant is icache): dc, ic, dc
        drv(0, 1, 32'h11, 1, 0, 1, 32'h22, 2, 1, 0, 0);
        check("t3_tie1_dc", o_dc_ready, 1);
        check("t3_tie1_ic", o_ic_ready, 0);
        check("t3_tie1_addr", o_mem_addr, 32'h22);
        next_cyc();
        drv(0, 1, 32'h11, 1, 0, 0, 0, 0, 1, 0, 0);
        check("t3_hold_ic", o_ic_ready, 0);
        next_cyc();
        drv(0, 1, 32'h11, 1, 0, 1, 32'h33, 3, 1, 0, 0);
        check("t3_tie2_ic", o_ic_ready, 1);
        check("t3_tie2_dc", o_dc_ready, 0);
        check("t3_tie2_addr", o_mem_addr, 32'h11);
        next_cyc();
        drv(0, 0, 0, 0, 0, 1, 32'h33, 3, 1, 0, 0);
        check("t3_hold_dc", o_dc_ready, 0);
        next_cyc();
        drv(0, 1, 32'h44, 4, 0, 1, 32'h33, 3, 1, 0, 0);
        check("t3_tie3_dc", o_dc_ready, 1);
        check("t3_tie3_ic", o_ic_ready, 0);
        check("t3_tie3_wdata", o_mem_wdata, 3);
        next_cyc();
        quiet();
        next_cyc();
        quiet();
        check("t3_idle", o_owner, 2'b00);

        // ---- dcache fills the 4-read window, 5th read waits for a response
        for (int k = 0; k < 4; k++) begin
            drv(0, 0, 0, 0, 1, 0, 32'h200 + 32'(4 * k), 0, 1, 0, 0);
            check($sformatf("t4_acc%0d", k), o_dc_ready, 1);
            next_cyc();
        end
        for (int k = 0; k < 2; k++) begin
            drv(0, 0, 0, 0, 1, 0, 32'h210, 0, 1, 0, 0);
            check($sformatf("t4_full_rdy%0d", k), o_dc_ready, 0);
            check($sformatf("t4_full_ren%0d", k), o_mem_ren, 0);
            next_cyc();
        end
        drv(0, 0, 0, 0, 1, 0, 32'h210, 0, 1, 1, 32'hB0);
        check("t4_v0_rdy", o_dc_ready, 0);
        check("t4_v0_valid", o_dc_valid, 1);
        next_cyc();
        drv(0, 0, 0, 0, 1, 0, 32'h210, 0, 1, 1, 32'hB1);
        check("t4_5th_rdy", o_dc_ready, 1);
        check("t4_5th_addr", o_mem_addr, 32'h210);
        check("t4_v1_valid", o_dc_valid, 1);
        next_cyc();
        for (int k = 0; k < 3; k++) begin
            drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'hB2 + 32'(k));
            check($sformatf("t4_owner%0d", k), o_owner, 2'b10);
            check($sformatf("t4_dcv%0d", k), o_dc_valid, 1);
            check($sformatf("t4_icv%0d", k), o_ic_valid, 0);
            next_cyc();
        end
        quiet();
        check("t4_released", o_owner, 2'b00);

        // ---- memory not ready for 3 cycles during a dcache read
        for (int k = 0; k < 4; k++) begin
            drv(0, 0, 0, 0, 1, 0, 32'h300, 0, k == 3, 0, 0);
            check($sformatf("t5_ready%0d", k), o_dc_ready, k == 3);
            check($sformatf("t5_owner%0d", k), o_owner, 2'b00);
            next_cyc();
        end
        drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'hC0);
        check("t5_valid", o_dc_valid, 1);
        check("t5_owner_d", o_owner, 2'b10);
        next_cyc();
        quiet();
        check("t5_released", o_owner, 2'b00);

        // ---- spurious response in IDLE
        check("t6_err_before", o_protocol_err, 0);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'hEE);
        check("t6_icv_drop", o_ic_valid, 0);
        check("t6_dcv_drop", o_dc_valid, 0);
        next_cyc();
        quiet();
        check("t6_err_set", o_protocol_err, 1);
        next_cyc();
        quiet();
        check("t6_err_sticky", o_protocol_err, 1);
        // counter must still be 0: one read plus one response releases
        drv(1, 0, 32'h500, 0, 0, 0, 0, 0, 1, 0, 0);
        next_cyc();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h55);
        check("t6_post_valid", o_ic_valid, 1);
        next_cyc();
        quiet();
        check("t6_post_idle", o_owner, 2'b00);

        // ---- reset mid-transaction clears error and counter
        drv(1, 0, 32'h600, 0, 0, 0, 0, 0, 1, 0, 0);
        next_cyc();
        quiet();
        check("t7_owner_busy", o_owner, 2'b01);
        i_rst_n = 1'b0;
        #1;
        check("t7_rst_err", o_protocol_err, 0);
        check("t7_rst_owner", o_owner, 2'b00);
        next_cyc();
        i_rst_n = 1'b1;
        drv(1, 1, 32'h700, 32'h77, 0, 0, 0, 0, 1, 0, 0);
        check("t7_rw_wen", o_mem_wen, 1);
        check("t7_rw_ren", o_mem_ren, 0);
        check("t7_rw_ready", o_ic_ready, 1);
        next_cyc();
        quiet();
        check("t7_rw_err", o_protocol_err, 1);
        check("t7_owner_i", o_owner, 2'b01);
        next_cyc();
        quiet();
        check("t7_cnt_cleared", o_owner, 2'b00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
